cordic_vectoring: RTL and testbench

Pipelined vectoring-mode CORDIC. It is the receive-side inverse of the oscillator lane, which converts phase to sin/cos. This block converts a signed I/Q sample (cos, sin) back to a full-turn phase word and an unnormalised magnitude. It feeds the demodulator's phase/frequency detector and the loopback self-test. One instance serves one lane; the parallel datapath instantiates four.

---
 rtl/cordic_pkg.sv | 43 ++++
 rtl/cordic_vec_stage.sv | 53 +++++
 rtl/cordic_vectoring.sv | 110 +++++++++++
 tb/tb_cordic_vectoring.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, gain and internal width rule.
// Used by both the rotation (oscillator) and vectoring CORDIC lanes.
package cordic_pkg;

  // Gain of an infinite-stage CORDIC, Q1.15.
  localparam logic [15:0] CORDIC_K = 16'd53961;

  localparam int ATAN_ENTRIES = 30;

  typedef logic [31:0] atan32_t;

  // round(atan(2^-i) * 2^32 / (2*pi)); rescaled for other phase widths below.
  localparam atan32_t ATAN_TABLE32 [ATAN_ENTRIES] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001
  };

  // Two guard bits: one for negating -2^(DATA_W-1), one for the ~1.65 gain.
  function automatic int cordic_int_w(input int data_w);
    return data_w + 2;
  endfunction

  function automatic logic [63:0] cordic_atan(input int idx, input int phase_w);
    logic [63:0] t;
    t = 64'(ATAN_TABLE32[idx[4:0]]);
    if (phase_w >= 32) return t << (phase_w - 32);
    return (t + (64'd1 << (31 - phase_w))) >> (32 - phase_w);
  endfunction

  function automatic logic [63:0] cordic_atan_sum(input int iter, input int phase_w);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < iter; i++) s += cordic_atan(i, phase_w);
    return s;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring micro-rotation: drives y toward zero and
// accumulates the applied rotation angle into z.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int                 W       = 18,
  parameter int                 PHASE_W = 32,
  parameter int                 SHIFT   = 0,
  parameter logic [PHASE_W-1:0] ATAN    = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic signed [W-1:0]       x_i,
  input  logic signed [W-1:0]       y_i,
  input  logic        [PHASE_W-1:0] z_i,
  output logic                      valid_o,
  output logic signed [W-1:0]       x_o,
  output logic signed [W-1:0]       y_o,
  output logic        [PHASE_W-1:0] z_o
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  assign x_sh = x_i >>> SHIFT;
  assign y_sh = y_i >>> SHIFT;

  // NOTE: non-blocking assignments keep every stage sampling its neighbour's
  // pre-edge value, which is what makes the pipeline a pipeline.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: data registers are reset as well as valid so simulation never
      // carries X through the pipe; valid alone would suffice in silicon.
      valid_o <= 1'b0;
      x_o     <= '0;
      y_o     <= '0;
      z_o     <= '0;
    end else begin
      valid_o <= valid_i;
      if (!y_i[W-1]) begin
        x_o <= x_i + y_sh;
        y_o <= y_i - x_sh;
        z_o <= z_i + ATAN;
      end else begin
        x_o <= x_i - y_sh;
        y_o <= y_i + x_sh;
        z_o <= z_i - ATAN;
      end
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Pipelined vectoring CORDIC: signed I/Q in, full-turn phase and
// unnormalised magnitude out, ITER+2 cycles later, one sample per clock.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 32,
  parameter int ITER    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic signed [DATA_W-1:0]  cos_i,
  input  logic signed [DATA_W-1:0]  sin_i,
  output logic                      valid_o,
  output logic        [PHASE_W-1:0] phase_o,
  output logic        [DATA_W:0]    mag_o
);

  localparam int W = cordic_int_w(DATA_W);

  // (0,0) never leaves y>=0, so every stage adds its ATAN; pre-subtract the
  // total so the phase lands exactly on zero.
  localparam logic [PHASE_W-1:0] Z_ZERO_INIT =
    PHASE_W'(64'd0 - cordic_atan_sum(ITER, PHASE_W));
  localparam logic [PHASE_W-1:0] Z_HALF_TURN = {1'b1, {(PHASE_W-1){1'b0}}};

  logic signed [W-1:0]       cos_ext, sin_ext;
  logic signed [W-1:0]       pre_x, pre_y;
  logic        [PHASE_W-1:0] pre_z;
  logic signed [W-1:0]       pre_x_q, pre_y_q;
  logic        [PHASE_W-1:0] pre_z_q;
  logic                      pre_v_q;

  logic signed [W-1:0]       x_s [ITER+1];
  logic signed [W-1:0]       y_s [ITER+1];
  logic        [PHASE_W-1:0] z_s [ITER+1];
  logic                      v_s [ITER+1];

  assign cos_ext = W'(cos_i);
  assign sin_ext = W'(sin_i);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    pre_x = cos_ext;
    pre_y = sin_ext;
    pre_z = '0;
    if (cos_ext[W-1]) begin
      pre_x = -cos_ext;
      pre_y = -sin_ext;
      pre_z = Z_HALF_TURN;
    end else if (cos_ext == '0 && sin_ext == '0) begin
      pre_z = Z_ZERO_INIT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pre_v_q <= 1'b0;
      pre_x_q <= '0;
      pre_y_q <= '0;
      pre_z_q <= '0;
    end else begin
      pre_v_q <= valid_i;
      pre_x_q <= pre_x;
      pre_y_q <= pre_y;
      pre_z_q <= pre_z;
    end
  end

  assign v_s[0] = pre_v_q;
  assign x_s[0] = pre_x_q;
  assign y_s[0] = pre_y_q;
  assign z_s[0] = pre_z_q;

  for (genvar i = 0; i < ITER; i++) begin : g_stage
    cordic_vec_stage #(
      .W       (W),
      .PHASE_W (PHASE_W),
      .SHIFT   (i),
      .ATAN    (PHASE_W'(cordic_atan(i, PHASE_W)))
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (v_s[i]),
      .x_i     (x_s[i]),
      .y_i     (y_s[i]),
      .z_i     (z_s[i]),
      .valid_o (v_s[i+1]),
      .x_o     (x_s[i+1]),
      .y_o     (y_s[i+1]),
      .z_o     (z_s[i+1])
    );
  end

  // x has converged to a non-negative value below 2^(DATA_W+1).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o <= 1'b0;
      phase_o <= '0;
      mag_o   <= '0;
    end else begin
      valid_o <= v_s[ITER];
      phase_o <= z_s[ITER];
      mag_o   <= (DATA_W+1)'(x_s[ITER]);
    end
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Randomised bench for cordic_vectoring against a real-valued atan2/hypot
// model, with reset, axis, corner, streaming and loopback scenarios.
module tb_cordic_vectoring;

  localparam int     DATA_W  = 16;
  localparam int     PHASE_W = 32;
  localparam int     ITER    = 16;
  localparam int     LAT     = ITER + 2;
  localparam real    TWO_PI  = 6.283185307179586;
  localparam real    FULL    = 4294967296.0;
  localparam longint TURN    = 64'sd4294967296;
  localparam longint HALF    = 64'sd2147483648;
  // Each floor-shift stage can leave up to ~1 LSB on x and y, scaled by gain.
  localparam real    STAGE_ERR = 1.7 * ITER;

  typedef struct {
    bit  v;
    real ph;
    real mg;
    bit  exact;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst_i;
  logic                      valid_i;
  logic signed [DATA_W-1:0]  cos_i;
  logic signed [DATA_W-1:0]  sin_i;
  logic                      valid_o;
  logic        [PHASE_W-1:0] phase_o;
  logic        [DATA_W:0]    mag_o;

  int   errors = 0;
  int   checks = 0;
  real  k_gain;
  exp_t pipe_q[$];

  always #5 clk = ~clk;

  cordic_vectoring #(
    .DATA_W  (DATA_W),
    .PHASE_W (PHASE_W),
    .ITER    (ITER)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .cos_i   (cos_i),
    .sin_i   (sin_i),
    .valid_o (valid_o),
    .phase_o (phase_o),
    .mag_o   (mag_o)
  );

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol);
    checks++;
    if (got > exp + tol || got < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", tag, got, exp, tol);
    end
  endtask

  function automatic exp_t model(input bit v, input int ci, input int si);
    exp_t e;
    real  p;
    e.v     = v;
    e.exact = (ci == 0 && si == 0);
    p = $atan2(real'(si), real'(ci)) / TWO_PI * FULL;
    if (p < 0.0) p += FULL;
    e.ph = p;
    e.mg = k_gain * $sqrt(real'(ci) * real'(ci) + real'(si) * real'(si));
    return e;
  endfunction

  task automatic model_reset();
    exp_t idle;
    idle = model(1'b0, 0, 0);
    pipe_q.delete();
    repeat (LAT) pipe_q.push_back(idle);
  endtask

  task automatic compare(input exp_t e);
    longint ph_exp, ph_tol, mg_tol;
    check("valid", longint'(valid_o), longint'(e.v), 0);
    if (e.v) begin
      ph_exp = longint'(e.ph);
      if (longint'(phase_o) - ph_exp > HALF) ph_exp += TURN;
      if (longint'(phase_o) - ph_exp < -HALF) ph_exp -= TURN;
      if (e.exact) begin
        ph_tol = 0;
        mg_tol = 0;
      end else begin
        ph_tol = longint'(65536.0 + $atan2(STAGE_ERR + 1.0, e.mg) / TWO_PI * FULL);
        mg_tol = longint'(4.0 + STAGE_ERR);
      end
      check("phase", longint'(phase_o), ph_exp, ph_tol);
      check("mag", longint'(mag_o), longint'(e.mg), mg_tol);
    end
  endtask

  task automatic step(input bit v, input int ci, input int si, input exp_t e);
    @(posedge clk);
    #1;
    compare(pipe_q.pop_front());
    valid_i = v;
    cos_i   = DATA_W'(ci);
    sin_i   = DATA_W'(si);
    pipe_q.push_back(e);
  endtask

  task automatic drive(input bit v, input int ci, input int si);
    step(v, ci, si, model(v, ci, si));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, longint'(valid_o), 0, 0);
    check({tag, "_phase"}, longint'(phase_o), 0, 0);
    check({tag, "_mag"},   longint'(mag_o),   0, 0);
  endtask

  initial begin
    logic signed [DATA_W-1:0] ri, rq;
    exp_t e;
    real  ang;
    longint p;

    k_gain = 1.0;
    for (int i = 0; i < ITER; i++) k_gain *= $sqrt(1.0 + 2.0 ** (-2 * i));

    // Reset held with valid toggling: outputs stay cleared.
    rst_i = 1'b0; valid_i = 1'b0; cos_i = '0; sin_i = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      valid_i = c[0];
      cos_i   = 16'sd1000;
      check_zero_outputs("rst_hold");
    end
    valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    model_reset();

    // First sample after reset, then bubbles to pin down exact latency.
    drive(1'b1, 16384, 0);
    repeat (LAT + 2) drive(1'b0, 0, 0);

    // Axes, corners and the origin.
    drive(1'b1, 0, 16384);
    drive(1'b1, -16384, 0);
    drive(1'b1, 0, -16384);
    drive(1'b1, -32768, -32768);
    drive(1'b1, 0, 0);
    drive(1'b1, 32767, -32768);
    drive(1'b1, -32768, 0);
    drive(1'b1, 0, 1);
    repeat (LAT) drive(1'b0, 0, 0);

    // Random streaming with bubbles.
    for (int n = 0; n < 2000; n++) begin
      ri = DATA_W'($urandom);
      rq = DATA_W'($urandom);
      drive($urandom_range(0, 3) != 0, int'(ri), int'(rq));
    end

    // Loopback from a phase accumulator stepping 1/5 turn per sample.
    p = 0;
    for (int n = 0; n < 20; n++) begin
      ang = real'(p) / FULL * TWO_PI;
      ri  = DATA_W'($rtoi($floor(30000.0 * $cos(ang) + 0.5)));
      rq  = DATA_W'($rtoi($floor(30000.0 * $sin(ang) + 0.5)));
      e    = model(1'b1, int'(ri), int'(rq));
      e.ph = real'(p);
      e.mg = k_gain * 30000.0;
      step(1'b1, int'(ri), int'(rq), e);
      p = (p + 64'sh33333333) % TURN;
    end

    // Reset pulse while the pipe is full: valid drops at once, nothing stale follows.
    for (int n = 0; n < LAT; n++) drive(1'b1, 12000 - n * 1000, 5000 + n * 300);
    @(posedge clk);
    #1;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    rst_i = 1'b1;
    model_reset();
    repeat (LAT + 4) drive(1'b0, 0, 0);
    drive(1'b1, -20000, 7000);
    repeat (LAT + 1) drive(1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
